// File: rtl/freq_autorange_ctrl_if.sv
// Link between the autorange controller and the frequency_counter datapath:
// gate period configuration goes out, end-of-gate results come back.
interface freq_autorange_ctrl_if #(
    parameter int PERIOD_W = 12,
    parameter int COUNT_W  = 7
);
    logic [PERIOD_W-1:0] period;
    logic                period_load;
    logic                result_valid;
    logic [COUNT_W-1:0]  result_count;
    logic                result_ovf;

    modport master (
        output period,
        output period_load,
        input  result_valid,
        input  result_count,
        input  result_ovf
    );

    modport slave (
        input  period,
        input  period_load,
        output result_valid,
        output result_count,
        output result_ovf
    );
endinterface

// File: rtl/freq_autorange_ctrl.sv
// Autoranging gate controller: picks the gate period for the frequency counter and
// steps the range until each reading falls inside the displayable window.
module freq_autorange_ctrl #(
    parameter int PERIOD_W    = 12,
    parameter int COUNT_W     = 7,
    parameter int PERIOD_BASE = 10,
    parameter int MAX_RANGE   = 7,
    parameter int INIT_RANGE  = 3,
    parameter int LOW_THRESH  = 10,
    parameter int TIMEOUT     = 8192
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  manual_en,
    input  logic [2:0]            manual_range,
    freq_autorange_ctrl_if.master cnt_if,
    output logic [2:0]            range,
    output logic                  locked,
    output logic                  range_change,
    output logic                  timeout
);

    localparam int                  TCNT_W    = $clog2(TIMEOUT);
    localparam logic [2:0]          MAX_R     = 3'(MAX_RANGE);
    localparam logic [2:0]          INIT_R    = 3'(INIT_RANGE);
    localparam logic [COUNT_W-1:0]  LOW_T     = COUNT_W'(LOW_THRESH);
    localparam logic [TCNT_W-1:0]   TCNT_LAST = TCNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_EVAL
    } state_e;

    function automatic logic [PERIOD_W-1:0] period_of(input logic [2:0] r);
        return PERIOD_W'(PERIOD_BASE) << r;
    endfunction

    state_e               state_q, state_d;
    logic [2:0]           range_q, range_d;
    logic [PERIOD_W-1:0]  period_q, period_d;
    logic                 period_load_q, period_load_d;
    logic                 locked_q, locked_d;
    logic                 range_change_q, range_change_d;
    logic                 timeout_q, timeout_d;
    logic [TCNT_W-1:0]    tcnt_q, tcnt_d;
    logic                 discard_q, discard_d;
    logic [COUNT_W-1:0]   count_q, count_d;
    logic                 ovf_q, ovf_d;
    logic                 tmo_evt_q, tmo_evt_d;
    logic [2:0]           target;

    assign target = (manual_range > MAX_R) ? MAX_R : manual_range;

    // NOTE: every variable is given a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        range_d   = range_q;
        locked_d  = locked_q;
        timeout_d = timeout_q;
        tcnt_d    = tcnt_q;
        discard_d = discard_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        tmo_evt_d = tmo_evt_q;

        if (!enable) begin
            state_d  = S_IDLE;
            locked_d = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d = S_LOAD;
                    if (manual_en) begin
                        range_d = target;
                    end
                end

                S_LOAD: begin
                    discard_d = 1'b1;
                    tcnt_d    = '0;
                    state_d   = S_WAIT;
                end

                S_WAIT: begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                    if (manual_en && (target != range_q)) begin
                        range_d  = target;
                        locked_d = 1'b0;
                        state_d  = S_LOAD;
                    end else if (cnt_if.result_valid) begin
                        tcnt_d = '0;
                        if (discard_q) begin
                            // First gate after a load is partial; drop it.
                            discard_d = 1'b0;
                        end else begin
                            count_d   = cnt_if.result_count;
                            ovf_d     = cnt_if.result_ovf;
                            tmo_evt_d = 1'b0;
                            state_d   = S_EVAL;
                        end
                    end else if (tcnt_q == TCNT_LAST) begin
                        timeout_d = 1'b1;
                        count_d   = '0;
                        ovf_d     = 1'b0;
                        tmo_evt_d = 1'b1;
                        state_d   = S_EVAL;
                    end
                end

                S_EVAL: begin
                    tcnt_d = '0;
                    if (!tmo_evt_q) begin
                        timeout_d = 1'b0;
                    end
                    if (manual_en) begin
                        if (target != range_q) begin
                            range_d  = target;
                            locked_d = 1'b0;
                        end else begin
                            locked_d = ~ovf_q;
                        end
                    end else if (ovf_q) begin
                        locked_d = 1'b0;
                        if (range_q != 3'd0) begin
                            range_d = range_q - 3'd1;
                        end
                    end else if (count_q < LOW_T) begin
                        locked_d = 1'b0;
                        if (range_q != MAX_R) begin
                            range_d = range_q + 3'd1;
                        end
                    end else begin
                        locked_d = 1'b1;
                    end
                    state_d = (range_d != range_q) ? S_LOAD : S_WAIT;
                end

                default: state_d = S_IDLE;
            endcase
        end

        range_change_d = (range_d != range_q);
        period_d       = period_of(range_d);
        period_load_d  = (state_d == S_LOAD);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            range_q        <= INIT_R;
            period_q       <= period_of(INIT_R);
            period_load_q  <= 1'b0;
            locked_q       <= 1'b0;
            range_change_q <= 1'b0;
            timeout_q      <= 1'b0;
            tcnt_q         <= '0;
            discard_q      <= 1'b0;
            count_q        <= '0;
            ovf_q          <= 1'b0;
            tmo_evt_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            range_q        <= range_d;
            period_q       <= period_d;
            period_load_q  <= period_load_d;
            locked_q       <= locked_d;
            range_change_q <= range_change_d;
            timeout_q      <= timeout_d;
            tcnt_q         <= tcnt_d;
            discard_q      <= discard_d;
            count_q        <= count_d;
            ovf_q          <= ovf_d;
            tmo_evt_q      <= tmo_evt_d;
        end
    end

    assign cnt_if.period      = period_q;
    assign cnt_if.period_load = period_load_q;
    assign range              = range_q;
    assign locked             = locked_q;
    assign range_change       = range_change_q;
    assign timeout            = timeout_q;

endmodule
